gb_instr_issuer: RTL and testbench
==================================

Name: gb_instr_issuer

Overview:
Synthesizable instruction source for the gbprocessor ALU/register datapath; it is the driving end of the instruction/valid/probe interface.
- Holds a small loadable program memory of 8-bit opcodes.
- On start, issues the opcodes one at a time with a single-cycle valid, paced by a fixed gap.
- Captures the processor probe a fixed latency after each issue, tagged with the opcode index.
- Replaces hand-written stimulus loops in system-level benches and on-chip self-test.

Parameters:
ADDR_W, 5, program memory address width; depth = 2**ADDR_W entries
ISSUE_GAP, 2, idle cycles between consecutive valid pulses; 0 = back-to-back
PROBE_LAT, 1, cycles from a valid pulse to the cycle in which probe reflects that instruction (>=1)
PROBE_W, 8, probe width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
prog_we  in  1  program write strobe
prog_addr  in  ADDR_W  program write address
prog_data  in  8  opcode to write
prog_len  in  ADDR_W+1  number of opcodes to issue; sampled on start
start  in  1  start request, level-sampled
instruction  out  8  opcode to processor
valid  out  1  instruction qualifier to processor
probe  in  PROBE_W  processor observation bus
result_data  out  PROBE_W  captured probe value
result_idx  out  ADDR_W  index of the instruction that produced result_data
result_valid  out  1  one-cycle pulse: result_data/result_idx valid
busy  out  1  high from start acceptance until done
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (reset=0, async) forces the following; memory contents are not reset.
  - State IDLE.
  - instruction=0x00, valid=0, result_data=0, result_idx=0, result_valid=0, busy=0, done=0.
  - Probe tag pipeline cleared.
- Reset mid-run aborts immediately: no done, no further result_valid.
- States: IDLE, ISSUE, GAP, DRAIN, FIN.
- IDLE
  - prog_we=1 writes mem[prog_addr] = prog_data.
  - start=1 and prog_len=0: go to FIN; done pulses the next cycle.
  - start=1 and prog_len>0: latch len = min(prog_len, 2**ADDR_W), idx=0, busy=1, go to ISSUE.
  - start and prog_we in the same cycle: the write completes; start uses the pre-write memory contents.
- ISSUE (one cycle)
  - valid=1, instruction=mem[idx].
  - Push tag {idx} into the probe pipeline.
  - Last opcode: go to DRAIN. Otherwise idx++ and go to GAP; if ISSUE_GAP=0, stay in ISSUE.
- GAP: valid=0 for exactly ISSUE_GAP cycles, then ISSUE. The issue period is ISSUE_GAP+1 cycles.
- instruction holds its last value while valid=0.
- Timing: start sampled at edge N gives the first valid in the cycle after edge N.
- Probe pipeline: PROBE_LAT-deep shift register of {tag_valid, idx}, advancing every cycle, independent of the FSM.
  - When a tag emerges: register result_data=probe and result_idx=idx, and pulse result_valid.
  - Results are therefore visible PROBE_LAT+1 cycles after the corresponding valid cycle.
- DRAIN: wait until the pipeline holds no valid tag and the final result has been output, then go to FIN.
- FIN: done=1 for one cycle, busy=0, then IDLE.
- While busy: prog_we is ignored (memory protected) and start is ignored.
- idx counts 0..len-1 with no wrap. len = 2**ADDR_W issues the full memory; a prog_len above depth is clamped.

Optional Feature:
Macro GB_ISSUER_SWEEP_EN.
- Defined: adds input sweep (1 bit), sampled with start.
  - sweep=1 ignores memory and prog_len and issues opcodes 0x00..0xFF incrementing: 256 issues, same pacing and probe capture.
  - result_idx carries the low ADDR_W bits of the opcode.
- Not defined: port absent; memory-driven issue only.

Decomposition:
- Package gb_issuer_pkg:
  - state enum issuer_state_t {IDLE, ISSUE, GAP, DRAIN, FIN}
  - opcode width constant GB_OP_W=8
  - probe tag struct {logic vld; logic [ADDR_W-1:0] idx} via a parameterised typedef helper
- Sub-module gb_probe_capture: the PROBE_LAT tag pipeline plus result registers.
- FSM, gap counter and memory live in the top.

Test Plan:
- Reset mid-run: reset=0 during GAP → all outputs 0 immediately; after release no done and no result_valid; a new start runs from idx 0.
- Basic program: write 0x3C,0x80,0x05 at addresses 0..2, prog_len=3, start → valid pulses carrying 0x3C,0x80,0x05 exactly 3 cycles apart; result_idx 0,1,2 each PROBE_LAT+1 cycles after its valid; done once after the last result.
- Back-to-back: ISSUE_GAP=0, prog_len=32 → valid high for 32 consecutive cycles; 32 result pulses; done exactly once.
- Zero/oversize length: prog_len=0 → done the cycle after start and no valid; prog_len=63 → clamped to 32 issues.
- Protection: prog_we to addr 1 with 0xFF while busy → memory unchanged; the next run still issues the original opcode; start while busy is ignored.
- Sweep (GB_ISSUER_SWEEP_EN): sweep=1, start → 256 valids with opcodes 0x00..0xFF in order; 256 result pulses, then done.

Source files
------------

// File: rtl/gb_issuer_pkg.sv
// Shared types and constants for the gbprocessor instruction issuer.
// The probe tag record is sized per instance inside gb_probe_capture because its width follows ADDR_W.
package gb_issuer_pkg;

    localparam int GB_OP_W   = 8;
    localparam int SWEEP_OPS = 256;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GAP,
        DRAIN,
        FIN
    } issuer_state_t;

endpackage

// File: rtl/gb_probe_capture.sv
// Delays each issue tag by PROBE_LAT cycles, then registers the probe bus against it.
// tags_pending lets the issuer know when the final result has left the pipeline.
module gb_probe_capture #(
    parameter int ADDR_W    = 5,
    parameter int PROBE_LAT = 1,
    parameter int PROBE_W   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tag_vld,
    input  logic [ADDR_W-1:0]  tag_idx,
    input  logic [PROBE_W-1:0] probe,
    output logic [PROBE_W-1:0] result_data,
    output logic [ADDR_W-1:0]  result_idx,
    output logic               result_valid,
    output logic               tags_pending
);

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] idx;
    } probe_tag_t;

    probe_tag_t tag_pipe [PROBE_LAT];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PROBE_LAT; i++) tag_pipe[i] <= '0;
            result_data  <= '0;
            result_idx   <= '0;
            result_valid <= 1'b0;
        end else begin
            tag_pipe[0] <= '{vld: tag_vld, idx: tag_idx};
            for (int i = 1; i < PROBE_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
            // Tag leaves the pipeline in the cycle the probe reflects its instruction
            result_valid <= tag_pipe[PROBE_LAT-1].vld;
            if (tag_pipe[PROBE_LAT-1].vld) begin
                result_data <= probe;
                result_idx  <= tag_pipe[PROBE_LAT-1].idx;
            end
        end
    end

    always_comb begin
        tags_pending = 1'b0;
        for (int i = 0; i < PROBE_LAT; i++) tags_pending = tags_pending | tag_pipe[i].vld;
    end

endmodule

// File: rtl/gb_instr_issuer.sv
// Program-memory driven instruction source for the gbprocessor datapath with probe capture.
// Optional macro GB_ISSUER_SWEEP_EN adds a sweep input that issues opcodes 0x00..0xFF instead of memory.
module gb_instr_issuer
    import gb_issuer_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int ISSUE_GAP = 2,
    parameter int PROBE_LAT = 1,
    parameter int PROBE_W   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [GB_OP_W-1:0] prog_data,
    input  logic [ADDR_W:0]    prog_len,
    input  logic               start,
`ifdef GB_ISSUER_SWEEP_EN
    input  logic               sweep,
`endif
    output logic [GB_OP_W-1:0] instruction,
    output logic               valid,
    input  logic [PROBE_W-1:0] probe,
    output logic [PROBE_W-1:0] result_data,
    output logic [ADDR_W-1:0]  result_idx,
    output logic               result_valid,
    output logic               busy,
    output logic               done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;
    localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((ISSUE_GAP > 0) ? ISSUE_GAP - 1 : 0);

    issuer_state_t      state;
    logic [GB_OP_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]   idx;
    logic [CNT_W-1:0]   len;
    logic [CNT_W-1:0]   idx_next;
    logic [GAP_W-1:0]   gap_cnt;
    logic [GB_OP_W-1:0] next_op;
    logic               sweep_mode;
    logic               sweep_req;
    logic               last_issue;
    logic               tags_pending;

    // Lengths beyond the memory depth saturate to a full-memory run
    function automatic logic [CNT_W-1:0] sat_len(input logic [ADDR_W:0] req);
        if (int'(req) > DEPTH) return CNT_W'(DEPTH);
        return CNT_W'(req);
    endfunction

`ifdef GB_ISSUER_SWEEP_EN
    assign sweep_req = sweep;
`else
    assign sweep_req = 1'b0;
`endif

    assign idx_next   = idx + CNT_W'(1);
    assign last_issue = (idx == len - CNT_W'(1));
    assign next_op    = sweep_mode ? idx_next[GB_OP_W-1:0] : mem[idx_next[ADDR_W-1:0]];

    // Writes only land while idle, so a running program cannot be altered
    always_ff @(posedge clock) begin
        if (prog_we && state == IDLE) mem[prog_addr] <= prog_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            instruction <= '0;
            valid       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            idx         <= '0;
            len         <= '0;
            gap_cnt     <= '0;
            sweep_mode  <= 1'b0;
        end else begin
            valid <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (sweep_req) begin
                            len         <= CNT_W'(SWEEP_OPS);
                            sweep_mode  <= 1'b1;
                            idx         <= '0;
                            busy        <= 1'b1;
                            valid       <= 1'b1;
                            instruction <= '0;
                            state       <= ISSUE;
                        end else if (prog_len == '0) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            len         <= sat_len(prog_len);
                            sweep_mode  <= 1'b0;
                            idx         <= '0;
                            busy        <= 1'b1;
                            valid       <= 1'b1;
                            instruction <= mem[{ADDR_W{1'b0}}];
                            state       <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (last_issue) begin
                        state <= DRAIN;
                    end else if (ISSUE_GAP == 0) begin
                        idx         <= idx_next;
                        valid       <= 1'b1;
                        instruction <= next_op;
                    end else begin
                        gap_cnt <= GAP_LOAD;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        idx         <= idx_next;
                        valid       <= 1'b1;
                        instruction <= next_op;
                        state       <= ISSUE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                DRAIN: begin
                    if (!tags_pending) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    gb_probe_capture #(
        .ADDR_W   (ADDR_W),
        .PROBE_LAT(PROBE_LAT),
        .PROBE_W  (PROBE_W)
    ) u_capture (
        .clock       (clock),
        .reset       (reset),
        .tag_vld     (valid),
        .tag_idx     (idx[ADDR_W-1:0]),
        .probe       (probe),
        .result_data (result_data),
        .result_idx  (result_idx),
        .result_valid(result_valid),
        .tags_pending(tags_pending)
    );

endmodule

// File: tb/tb_gb_instr_issuer.sv
// Directed bench for gb_instr_issuer: instance a (gap 2, latency 1) and instance b (gap 0, latency 2).
// Sweep checks are included when GB_ISSUER_SWEEP_EN is defined.
`timescale 1ns/1ps
module tb_gb_instr_issuer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic       prog_we;
    logic [4:0] prog_addr;
    logic [7:0] prog_data;
    logic [5:0] prog_len;
    logic       start_a, start_b;
`ifdef GB_ISSUER_SWEEP_EN
    logic       sweep;
`endif
    logic [7:0] instruction_a, instruction_b, probe_a, probe_b, pipe_b;
    logic [7:0] result_data_a, result_data_b;
    logic [4:0] result_idx_a, result_idx_b;
    logic       valid_a, valid_b, result_valid_a, result_valid_b;
    logic       busy_a, busy_b, done_a, done_b;

    gb_instr_issuer #(.ADDR_W(5), .ISSUE_GAP(2), .PROBE_LAT(1), .PROBE_W(8)) dut_a (
        .clock(clock), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .start(start_a),
`ifdef GB_ISSUER_SWEEP_EN
        .sweep(sweep),
`endif
        .instruction(instruction_a), .valid(valid_a), .probe(probe_a),
        .result_data(result_data_a), .result_idx(result_idx_a), .result_valid(result_valid_a),
        .busy(busy_a), .done(done_a)
    );

    gb_instr_issuer #(.ADDR_W(5), .ISSUE_GAP(0), .PROBE_LAT(2), .PROBE_W(8)) dut_b (
        .clock(clock), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .start(start_b),
`ifdef GB_ISSUER_SWEEP_EN
        .sweep(1'b0),
`endif
        .instruction(instruction_b), .valid(valid_b), .probe(probe_b),
        .result_data(result_data_b), .result_idx(result_idx_b), .result_valid(result_valid_b),
        .busy(busy_b), .done(done_b)
    );

    // Processor stand-in: probe shows opcode^0xA5 exactly PROBE_LAT cycles after its valid, 0 otherwise
    always @(posedge clock) begin
        probe_a <= valid_a ? (instruction_a ^ 8'hA5) : 8'h00;
        pipe_b  <= valid_b ? (instruction_b ^ 8'hA5) : 8'h00;
        probe_b <= pipe_b;
    end

    typedef struct { int cyc; int op; int idx; } ev_t;
    ev_t va[$], ra[$], vb[$], rb[$];
    int  cyc = 0;
    int  done_a_cnt = 0, done_b_cnt = 0, done_a_cyc = -1, done_b_cyc = -1;
    int  n_checks = 0, n_errors = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (valid_a)        va.push_back('{cyc, int'(instruction_a), 0});
        if (result_valid_a) ra.push_back('{cyc, int'(result_data_a), int'(result_idx_a)});
        if (done_a) begin done_a_cnt++; done_a_cyc = cyc; end
        if (valid_b)        vb.push_back('{cyc, int'(instruction_b), 0});
        if (result_valid_b) rb.push_back('{cyc, int'(result_data_b), int'(result_idx_b)});
        if (done_b) begin done_b_cnt++; done_b_cyc = cyc; end
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clr();
        va.delete(); ra.delete(); vb.delete(); rb.delete();
        done_a_cnt = 0; done_b_cnt = 0; done_a_cyc = -1; done_b_cyc = -1;
    endtask

    task automatic prog_write(input int a, input int d);
        prog_we = 1'b1; prog_addr = 5'(a); prog_data = 8'(d);
        tick(1);
        prog_we = 1'b0;
    endtask

    task automatic run_a(input int len, output int t0);
        prog_len = 6'(len); start_a = 1'b1;
        tick(1);
        t0 = cyc; start_a = 1'b0;
    endtask

    task automatic wait_done(input bit sel_b, input int budget);
        int n = 0;
        while ((sel_b ? done_b_cnt : done_a_cnt) == 0 && n < budget) begin
            tick(1);
            n++;
        end
        if ((sel_b ? done_b_cnt : done_a_cnt) == 0) check_val("done_timeout", 0, 1);
        tick(3);
    endtask

    function automatic int op_of(input int i);
        case (i)
            0:       return 'h3C;
            1:       return 'h80;
            2:       return 'h05;
            default: return (i * 9 + 1) & 'hFF;
        endcase
    endfunction

    initial begin
        int t0;
        reset = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
        start_a = 1'b0; start_b = 1'b0;
`ifdef GB_ISSUER_SWEEP_EN
        sweep = 1'b0;
`endif
        tick(2);
        check_val("rst_instruction", int'(instruction_a), 0);
        check_val("rst_valid", int'(valid_a), 0);
        check_val("rst_result_valid", int'(result_valid_a), 0);
        check_val("rst_busy_done", int'({busy_a, done_a}), 0);
        check_val("rst_result", int'({result_data_a, result_idx_a}), 0);
        reset = 1'b1;
        tick(1);
        for (int i = 0; i < 32; i++) prog_write(i, op_of(i));

        // Basic three-opcode program
        clr();
        run_a(3, t0);
        check_val("basic_busy", int'(busy_a), 1);
        wait_done(1'b0, 60);
        check_val("basic_nvalid", va.size(), 3);
        check_val("basic_first_cyc", va.size() > 0 ? va[0].cyc : -1, t0);
        for (int i = 0; i < va.size() && i < 3; i++) begin
            check_val($sformatf("basic_op%0d", i), va[i].op, op_of(i));
            if (i > 0) check_val($sformatf("basic_gap%0d", i), va[i].cyc - va[i-1].cyc, 3);
        end
        check_val("basic_nresult", ra.size(), 3);
        for (int i = 0; i < ra.size() && i < 3 && i < va.size(); i++) begin
            check_val($sformatf("basic_ridx%0d", i), ra[i].idx, i);
            check_val($sformatf("basic_rdata%0d", i), ra[i].op, op_of(i) ^ 'hA5);
            check_val($sformatf("basic_rcyc%0d", i), ra[i].cyc, va[i].cyc + 2);
        end
        check_val("basic_done_cnt", done_a_cnt, 1);
        check_val("basic_done_cyc", done_a_cyc, ra.size() > 2 ? ra[2].cyc + 1 : -1);
        check_val("basic_busy_end", int'(busy_a), 0);

        // Zero length: done next cycle, nothing issued
        clr();
        run_a(0, t0);
        wait_done(1'b0, 10);
        check_val("zero_nvalid", va.size(), 0);
        check_val("zero_done_cyc", done_a_cyc, t0);
        check_val("zero_done_cnt", done_a_cnt, 1);

        // Oversize length clamps to 32
        clr();
        run_a(63, t0);
        wait_done(1'b0, 200);
        check_val("over_nvalid", va.size(), 32);
        check_val("over_nresult", ra.size(), 32);
        check_val("over_last_op", va.size() == 32 ? va[31].op : -1, op_of(31));
        check_val("over_last_idx", ra.size() == 32 ? ra[31].idx : -1, 31);
        check_val("over_last_data", ra.size() == 32 ? ra[31].op : -1, op_of(31) ^ 'hA5);
        check_val("over_done_cnt", done_a_cnt, 1);

        // Back-to-back on instance b
        clr();
        prog_len = 6'd32; start_b = 1'b1;
        tick(1);
        t0 = cyc; start_b = 1'b0;
        wait_done(1'b1, 100);
        check_val("b2b_nvalid", vb.size(), 32);
        check_val("b2b_first_cyc", vb.size() > 0 ? vb[0].cyc : -1, t0);
        check_val("b2b_span", vb.size() == 32 ? vb[31].cyc - vb[0].cyc : -1, 31);
        check_val("b2b_op17", vb.size() == 32 ? vb[17].op : -1, op_of(17));
        check_val("b2b_nresult", rb.size(), 32);
        check_val("b2b_rcyc31", (rb.size() == 32 && vb.size() == 32) ? rb[31].cyc - vb[31].cyc : -1, 3);
        check_val("b2b_ridx31", rb.size() == 32 ? rb[31].idx : -1, 31);
        check_val("b2b_rdata0", rb.size() > 0 ? rb[0].op : -1, op_of(0) ^ 'hA5);
        check_val("b2b_done_cnt", done_b_cnt, 1);
        check_val("b2b_done_cyc", done_b_cyc, rb.size() == 32 ? rb[31].cyc + 1 : -1);

        // Protection: write and restart while busy are ignored
        clr();
        run_a(3, t0);
        tick(1);
        prog_write(1, 'hFF);
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        wait_done(1'b0, 60);
        check_val("prot_nvalid", va.size(), 3);
        check_val("prot_done_cnt", done_a_cnt, 1);
        clr();
        run_a(3, t0);
        wait_done(1'b0, 60);
        check_val("prot_op1", va.size() > 1 ? va[1].op : -1, 'h80);

        // Reset in GAP aborts the run
        clr();
        run_a(3, t0);
        tick(1);
        check_val("mid_instr_before", int'(instruction_a), 'h3C);
        #1 reset = 1'b0;
        #1;
        check_val("mid_instruction", int'(instruction_a), 0);
        check_val("mid_busy_valid", int'({busy_a, valid_a}), 0);
        check_val("mid_result", int'({result_data_a, result_idx_a, result_valid_a}), 0);
        #1 reset = 1'b1;
        clr();
        tick(12);
        check_val("mid_no_result", ra.size(), 0);
        check_val("mid_no_done", done_a_cnt, 0);
        check_val("mid_no_valid", va.size(), 0);
        run_a(3, t0);
        wait_done(1'b0, 60);
        check_val("mid_rerun_op0", va.size() > 0 ? va[0].op : -1, 'h3C);
        check_val("mid_rerun_idx0", ra.size() > 0 ? ra[0].idx : -1, 0);
        check_val("mid_rerun_n", ra.size(), 3);

`ifdef GB_ISSUER_SWEEP_EN
        // Sweep ignores memory and prog_len
        clr();
        sweep = 1'b1;
        run_a(5, t0);
        sweep = 1'b0;
        wait_done(1'b0, 900);
        check_val("sweep_nvalid", va.size(), 256);
        check_val("sweep_op100", va.size() == 256 ? va[100].op : -1, 100);
        check_val("sweep_op255", va.size() == 256 ? va[255].op : -1, 255);
        check_val("sweep_nresult", ra.size(), 256);
        check_val("sweep_ridx255", ra.size() == 256 ? ra[255].idx : -1, 31);
        check_val("sweep_rdata200", ra.size() == 256 ? ra[200].op : -1, 200 ^ 'hA5);
        check_val("sweep_done_cnt", done_a_cnt, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
